// File: rtl/fl_rr_arbiter.sv
// Frame-atomic round-robin FrameLink arbiter: one source owns the output from SOF to EOF,
// with a single arbitration cycle in IDLE between frames.
module fl_rr_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int INPUTS      = 4,
    parameter int DREM_WIDTH  = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int GRANT_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [INPUTS*DATA_WIDTH-1:0]     RX_DATA,
    input  logic [INPUTS*DREM_WIDTH-1:0]     RX_DREM,
    input  logic [INPUTS-1:0]                RX_SOF_N,
    input  logic [INPUTS-1:0]                RX_EOF_N,
    input  logic [INPUTS-1:0]                RX_SOP_N,
    input  logic [INPUTS-1:0]                RX_EOP_N,
    input  logic [INPUTS-1:0]                RX_SRC_RDY_N,
    output logic [INPUTS-1:0]                RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]            TX_DATA,
    output logic [DREM_WIDTH-1:0]            TX_DREM,
    output logic                             TX_SOF_N,
    output logic                             TX_EOF_N,
    output logic                             TX_SOP_N,
    output logic                             TX_EOP_N,
    output logic                             TX_SRC_RDY_N,
    input  logic                             TX_DST_RDY_N,
    output logic [GRANT_WIDTH-1:0]           GRANT,
    output logic                             BUSY
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    localparam logic [GRANT_WIDTH:0]   INPUTS_EXT = (GRANT_WIDTH + 1)'(INPUTS);
    localparam logic [GRANT_WIDTH-1:0] LAST_IDX   = GRANT_WIDTH'(INPUTS - 1);

    state_t                 state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q, grant_d;
    logic [GRANT_WIDTH-1:0] ptr_q, ptr_d;

    logic [INPUTS-1:0]      req;
    logic [INPUTS-1:0]      req_rot;
    logic                   found;
    logic [GRANT_WIDTH-1:0] sel_off;
    logic [GRANT_WIDTH:0]   sel_sum;
    logic [GRANT_WIDTH-1:0] sel_idx;

    logic [DATA_WIDTH-1:0]  g_data;
    logic [DREM_WIDTH-1:0]  g_drem;
    logic                   g_sof_n, g_eof_n, g_sop_n, g_eop_n, g_src_rdy_n;

    assign req   = ~RX_SRC_RDY_N & ~RX_SOF_N;
    assign GRANT = grant_q;

    // Rotate requests so bit 0 is the pointer position, take the lowest set bit, rotate back.
    always_comb begin
        req_rot = '0;
        for (int j = 0; j < INPUTS; j++) begin
            if (ptr_q == GRANT_WIDTH'(j)) begin
                for (int k = 0; k < INPUTS; k++) begin
                    req_rot[k] = req[(j + k) % INPUTS];
                end
            end
        end
        found   = |req_rot;
        sel_off = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            if (req_rot[k]) sel_off = GRANT_WIDTH'(k);
        end
        sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
        if (sel_sum >= INPUTS_EXT) sel_sum = sel_sum - INPUTS_EXT;
        sel_idx = sel_sum[GRANT_WIDTH-1:0];
    end

    always_comb begin
        g_data      = '0;
        g_drem      = '0;
        g_sof_n     = 1'b1;
        g_eof_n     = 1'b1;
        g_sop_n     = 1'b1;
        g_eop_n     = 1'b1;
        g_src_rdy_n = 1'b1;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_q == GRANT_WIDTH'(i)) begin
                g_data      = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                g_drem      = RX_DREM[i*DREM_WIDTH +: DREM_WIDTH];
                g_sof_n     = RX_SOF_N[i];
                g_eof_n     = RX_EOF_N[i];
                g_sop_n     = RX_SOP_N[i];
                g_eop_n     = RX_EOP_N[i];
                g_src_rdy_n = RX_SRC_RDY_N[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        TX_DATA      = '0;
        TX_DREM      = '0;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        BUSY         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOCKED;
                    grant_d = sel_idx;
                end
            end
            ST_LOCKED: begin
                TX_DATA      = g_data;
                TX_DREM      = g_drem;
                TX_SOF_N     = g_sof_n;
                TX_EOF_N     = g_eof_n;
                TX_SOP_N     = g_sop_n;
                TX_EOP_N     = g_eop_n;
                TX_SRC_RDY_N = g_src_rdy_n;
                BUSY         = 1'b1;
                for (int i = 0; i < INPUTS; i++) begin
                    if (grant_q == GRANT_WIDTH'(i)) RX_DST_RDY_N[i] = TX_DST_RDY_N;
                end
                // Release only on an accepted EOF word; the owner after us gets top priority.
                if (!g_src_rdy_n && !TX_DST_RDY_N && !g_eof_n) begin
                    state_d = ST_IDLE;
                    ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + GRANT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_fl_rr_arbiter.sv
// Bench for fl_rr_arbiter: directed frame scenarios plus randomized traffic, every cycle
// compared against a transfer-level round-robin model.
module tb_fl_rr_arbiter;
    localparam int DW = 32, N = 4, DRW = 2, GW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*DW-1:0]   rx_data;
    logic [N*DRW-1:0]  rx_drem;
    logic [N-1:0]      rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n;
    logic [N-1:0]      rx_dst_rdy_n;
    logic [DW-1:0]     tx_data;
    logic [DRW-1:0]    tx_drem;
    logic              tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n;
    logic              tx_dst_rdy_n;
    logic [GW-1:0]     grant;
    logic              busy;

    fl_rr_arbiter #(.DATA_WIDTH(DW), .INPUTS(N)) dut (
        .CLK(clk), .RESET(rst),
        .RX_DATA(rx_data), .RX_DREM(rx_drem),
        .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
        .RX_SRC_RDY_N(rx_src_rdy_n), .RX_DST_RDY_N(rx_dst_rdy_n),
        .TX_DATA(tx_data), .TX_DREM(tx_drem),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
        .TX_SRC_RDY_N(tx_src_rdy_n), .TX_DST_RDY_N(tx_dst_rdy_n),
        .GRANT(grant), .BUSY(busy)
    );

    int checks = 0, errors = 0;
    int cyc = 0, scen_start = 0;

    // Reference model: which source owns the output, and who has top priority next.
    bit m_busy;
    int m_g, m_p;

    // Source behaviour
    int f_left[N], len_cfg[N], cur_len[N], pos[N], frame_no[N], start_cyc[N];
    bit bad[N];
    bit hs[N];
    int stall_pct, bp_pct, bp_lo, bp_hi, rst_cyc;

    // Observation logs
    logic [DW-1:0] tx_log[$];
    int grant_log[$];
    int busy_cnt, first_busy, last_busy, dst1_low, hs_total;
    bit prev_busy;
    int busy_at[64], grant_at[64], txsrc_at[64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i, input int f, input int p);
        return {8'(i), 8'(f), 16'(p)};
    endfunction

    function automatic int pick_len(input int i);
        return (len_cfg[i] != 0) ? len_cfg[i] : int'($urandom_range(4, 1));
    endfunction

    function automatic bit active(input int i);
        return !bad[i] && f_left[i] > 0 && cyc >= start_cyc[i];
    endfunction

    task automatic clear_logs();
        tx_log.delete();
        grant_log.delete();
        busy_cnt = 0; first_busy = -1; last_busy = -1; dst1_low = 0; hs_total = 0;
        prev_busy = 1'b0;
        for (int k = 0; k < 64; k++) begin
            busy_at[k] = -1; grant_at[k] = -1; txsrc_at[k] = -1;
        end
    endtask

    task automatic setup_clear();
        for (int i = 0; i < N; i++) begin
            f_left[i] = 0; len_cfg[i] = 0; cur_len[i] = 1; pos[i] = 0;
            frame_no[i] = 0; start_cyc[i] = 0; bad[i] = 1'b0;
        end
        stall_pct = 0; bp_pct = 0; bp_lo = -1; bp_hi = -2; rst_cyc = -1;
        clear_logs();
    endtask

    task automatic cfg_src(input int i, input int frames, input int len, input int start);
        f_left[i]    = frames;
        len_cfg[i]   = len;
        cur_len[i]   = pick_len(i);
        pos[i]       = 0;
        start_cyc[i] = scen_start + start;
    endtask

    task automatic drive_inputs();
        rst = (cyc == rst_cyc);
        tx_dst_rdy_n = (cyc >= bp_lo && cyc <= bp_hi) ? 1'b1 : ($urandom_range(99) < bp_pct);
        for (int i = 0; i < N; i++) begin
            if (bad[i]) begin
                rx_src_rdy_n[i] = 1'b0;
                rx_sof_n[i] = 1'b1; rx_eof_n[i] = 1'b1; rx_sop_n[i] = 1'b1; rx_eop_n[i] = 1'b1;
                rx_data[i*DW +: DW]   = 32'hBAD0_0000 | 32'(i);
                rx_drem[i*DRW +: DRW] = '0;
            end else if (active(i)) begin
                rx_src_rdy_n[i] = ($urandom_range(99) < stall_pct);
                rx_sof_n[i] = !(pos[i] == 0);
                rx_eof_n[i] = !(pos[i] == cur_len[i] - 1);
                rx_sop_n[i] = rx_sof_n[i];
                rx_eop_n[i] = rx_eof_n[i];
                rx_data[i*DW +: DW]   = word(i, frame_no[i], pos[i]);
                rx_drem[i*DRW +: DRW] = DRW'(pos[i]);
            end else begin
                rx_src_rdy_n[i] = 1'b1;
                rx_sof_n[i] = 1'b1; rx_eof_n[i] = 1'b1; rx_sop_n[i] = 1'b1; rx_eop_n[i] = 1'b1;
                rx_data[i*DW +: DW]   = '0;
                rx_drem[i*DRW +: DRW] = '0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [38:0] exp_tx, obs_tx;
        logic [N-1:0] exp_dst;
        if (m_busy)
            exp_tx = {rx_data[m_g*DW +: DW], rx_drem[m_g*DRW +: DRW], rx_sof_n[m_g], rx_eof_n[m_g],
                      rx_sop_n[m_g], rx_eop_n[m_g], rx_src_rdy_n[m_g]};
        else
            exp_tx = {32'h0, 2'b00, 5'b11111};
        obs_tx = {tx_data, tx_drem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n};
        exp_dst = '1;
        if (m_busy) exp_dst[m_g] = tx_dst_rdy_n;
        chk("tx_bus", 64'(obs_tx), 64'(exp_tx));
        chk("rx_dst_rdy_n", 64'(rx_dst_rdy_n), 64'(exp_dst));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant", 64'(grant), 64'(m_g));
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = 1'b0; m_g = 0; m_p = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_p + k) % N;
                if (!rx_src_rdy_n[idx] && !rx_sof_n[idx]) begin
                    m_busy = 1'b1; m_g = idx;
                    break;
                end
            end
        end else if (!rx_src_rdy_n[m_g] && !tx_dst_rdy_n && !rx_eof_n[m_g]) begin
            m_busy = 1'b0;
            m_p = (m_g + 1) % N;
        end
    endtask

    task automatic source_update();
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                if (pos[i] > 0) begin
                    f_left[i] = 0; pos[i] = 0;
                end
            end else if (hs[i] && !bad[i]) begin
                if (pos[i] == cur_len[i] - 1) begin
                    pos[i] = 0; f_left[i]--; frame_no[i]++;
                    cur_len[i] = pick_len(i);
                end else begin
                    pos[i]++;
                end
            end
        end
    endtask

    task automatic step();
        int rel;
        @(negedge clk);
        check_outputs();
        rel = cyc - scen_start;
        if (busy === 1'b1) begin
            busy_cnt++;
            last_busy = rel;
            if (first_busy < 0) first_busy = rel;
            if (!prev_busy) grant_log.push_back(int'(grant));
        end
        prev_busy = (busy === 1'b1);
        if (rel >= 0 && rel < 64) begin
            busy_at[rel] = int'(busy); grant_at[rel] = int'(grant); txsrc_at[rel] = int'(tx_src_rdy_n);
        end
        if (tx_src_rdy_n === 1'b0 && tx_dst_rdy_n === 1'b0) tx_log.push_back(tx_data);
        if (rx_dst_rdy_n[1] === 1'b0) dst1_low++;
        for (int i = 0; i < N; i++) begin
            hs[i] = !rx_src_rdy_n[i] && (rx_dst_rdy_n[i] === 1'b0);
            if (hs[i]) hs_total++;
        end
        @(posedge clk);
        model_update();
        source_update();
        cyc++;
        #1 drive_inputs();
    endtask

    task automatic do_reset();
        setup_clear();
        drive_inputs();
        rst = 1'b1;
        @(posedge clk);
        m_busy = 1'b0; m_g = 0; m_p = 0;
        cyc++;
        #1 drive_inputs();
    endtask

    task automatic begin_scenario();
        setup_clear();
        do_reset();
        scen_start = cyc;
    endtask

    initial begin
        setup_clear();
        do_reset();
        do_reset();

        // Idle state straight after reset
        #2;
        chk("rst_tx_src_rdy_n", 64'(tx_src_rdy_n), 64'(1));
        chk("rst_rx_dst_rdy_n", 64'(rx_dst_rdy_n), 64'hF);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_framing", 64'({tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n}), 64'hF);
        chk("rst_data_drem", 64'({tx_data, tx_drem}), 64'(0));

        // Single 3-word frame from input 2
        begin_scenario();
        cfg_src(2, 1, 3, 0);
        drive_inputs();
        repeat (6) step();
        chk("s1_grants", 64'(grant_log.size()), 64'(1));
        if (grant_log.size() > 0) chk("s1_grant0", 64'(grant_log[0]), 64'(2));
        chk("s1_busy_cycles", 64'(busy_cnt), 64'(3));
        chk("s1_first_busy", 64'(first_busy), 64'(1));
        chk("s1_words", 64'(tx_log.size()), 64'(3));
        for (int k = 0; k < 3 && k < tx_log.size(); k++) chk("s1_word", 64'(tx_log[k]), 64'(word(2, 0, k)));
        // Pointer now favours input 3 over input 0
        clear_logs();
        scen_start = cyc;
        cfg_src(0, 1, 1, 0);
        cfg_src(3, 1, 1, 0);
        drive_inputs();
        repeat (6) step();
        chk("s1b_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            chk("s1b_first", 64'(grant_log[0]), 64'(3));
            chk("s1b_second", 64'(grant_log[1]), 64'(0));
        end

        // Inputs 0 and 1 request together
        begin_scenario();
        cfg_src(0, 1, 2, 0);
        cfg_src(1, 1, 2, 0);
        drive_inputs();
        repeat (8) step();
        chk("s2_busy_cycles", 64'(busy_cnt), 64'(4));
        chk("s2_last_busy", 64'(last_busy), 64'(5));
        chk("s2_words", 64'(tx_log.size()), 64'(4));
        if (tx_log.size() == 4) begin
            chk("s2_w0", 64'(tx_log[0]), 64'(word(0, 0, 0)));
            chk("s2_w1", 64'(tx_log[1]), 64'(word(0, 0, 1)));
            chk("s2_w2", 64'(tx_log[2]), 64'(word(1, 0, 0)));
            chk("s2_w3", 64'(tx_log[3]), 64'(word(1, 0, 1)));
        end

        // All inputs stream single-word frames
        begin_scenario();
        for (int i = 0; i < N; i++) cfg_src(i, 5, 1, 0);
        drive_inputs();
        repeat (42) step();
        chk("s3_grants", 64'(grant_log.size()), 64'(20));
        for (int k = 0; k < grant_log.size(); k++) chk("s3_rr_order", 64'(grant_log[k]), 64'(k % N));
        chk("s3_last_busy", 64'(last_busy), 64'(39));
        chk("s3_busy_cycles", 64'(busy_cnt), 64'(20));

        // Five cycles of output backpressure mid-frame
        begin_scenario();
        cfg_src(1, 1, 4, 0);
        bp_lo = scen_start + 2;
        bp_hi = scen_start + 6;
        drive_inputs();
        repeat (14) step();
        chk("s4_busy_cycles", 64'(busy_cnt), 64'(9));
        chk("s4_grants", 64'(grant_log.size()), 64'(1));
        chk("s4_words", 64'(tx_log.size()), 64'(4));
        for (int k = 0; k < 4 && k < tx_log.size(); k++) chk("s4_word", 64'(tx_log[k]), 64'(word(1, 0, k)));

        // Reset while input 3 is mid-frame; input 0 waiting
        begin_scenario();
        cfg_src(3, 1, 4, 0);
        cfg_src(0, 1, 2, 2);
        rst_cyc = scen_start + 3;
        drive_inputs();
        repeat (10) step();
        chk("s5_locked_before", 64'(grant_at[3]), 64'(3));
        chk("s5_idle_busy", 64'(busy_at[4]), 64'(0));
        chk("s5_idle_src_rdy", 64'(txsrc_at[4]), 64'(1));
        chk("s5_next_busy", 64'(busy_at[5]), 64'(1));
        chk("s5_next_grant", 64'(grant_at[5]), 64'(0));
        chk("s5_words", 64'(tx_log.size()), 64'(5));
        if (tx_log.size() == 5) chk("s5_w3", 64'(tx_log[3]), 64'(word(0, 0, 0)));

        // Non-SOF word from an ungranted input is not a request
        begin_scenario();
        bad[1] = 1'b1;
        drive_inputs();
        repeat (6) step();
        chk("s6_busy_cycles", 64'(busy_cnt), 64'(0));
        chk("s6_words", 64'(tx_log.size()), 64'(0));
        chk("s6_dst1_low", 64'(dst1_low), 64'(0));

        // Randomized traffic with stalls and backpressure
        begin_scenario();
        for (int i = 0; i < N; i++) cfg_src(i, int'($urandom_range(10, 3)), 0, int'($urandom_range(20, 0)));
        stall_pct = 20;
        bp_pct = 30;
        drive_inputs();
        for (int t = 0; t < 3000; t++) begin
            int left;
            step();
            left = 0;
            for (int i = 0; i < N; i++) left += f_left[i];
            if (left == 0 && !m_busy) break;
        end
        begin
            int left;
            left = 0;
            for (int i = 0; i < N; i++) left += f_left[i];
            chk("rand_frames_left", 64'(left), 64'(0));
        end
        chk("rand_words", 64'(tx_log.size()), 64'(hs_total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
